// File: rtl/lstm_mem_pkg.sv
// Shared constants and state encoding for the LSTM weight-memory sequencers.
package lstm_mem_pkg;

  localparam int HIDDEN_SIZE   = 128;
  localparam int WORDS_PER_ROW = HIDDEN_SIZE / 2;
  localparam int TOTAL_WORDS   = HIDDEN_SIZE * HIDDEN_SIZE / 2;
  localparam int WADDR_W       = $clog2(TOTAL_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/hh_weight_read_scheduler_if.sv
// Bus bundle between the scheduler, the weight memory, the loader and the MAC array.
// Handshakes: a loader write transfers on a cycle where ld_valid && ld_ready;
// a read is issued when mem_re is high and its tag appears one cycle later with rd_valid.
interface hh_weight_read_scheduler_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 14,
  parameter int HIDDEN_SIZE = 128
);
  localparam int WA = ADDR_WIDTH - 1;
  localparam int RW = $clog2(HIDDEN_SIZE);
  localparam int CW = $clog2(HIDDEN_SIZE / 2);

  logic                    mac_ready;
  logic                    ld_valid;
  logic                    ld_ready;
  logic [WA-1:0]           ld_addr;
  logic [2*DATA_WIDTH-1:0] ld_data;
  logic                    mem_we;
  logic [WA-1:0]           mem_waddr;
  logic [2*DATA_WIDTH-1:0] mem_wdata;
  logic                    mem_re;
  logic [WA-1:0]           mem_raddr;
  logic                    rd_valid;
  logic [RW-1:0]           rd_row;
  logic [CW-1:0]           rd_col;
  logic                    rd_row_last;
  logic                    rd_frame_last;

  modport slave (
    input  mac_ready, ld_valid, ld_addr, ld_data,
    output ld_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
           rd_valid, rd_row, rd_col, rd_row_last, rd_frame_last
  );

  modport master (
    output mac_ready, ld_valid, ld_addr, ld_data,
    input  ld_ready, mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr,
           rd_valid, rd_row, rd_col, rd_row_last, rd_frame_last
  );

endinterface

// File: rtl/hh_sched_perf_counters.sv
// Saturating stall / completed-sweep counters for the hidden-hidden read scheduler.
module hh_sched_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_inc,
  input  logic        stall_clr,
  input  logic        sweep_inc,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_sweep_cnt
);

  logic [15:0] stall_q, stall_d;
  logic [15:0] sweep_q, sweep_d;

  always_comb begin
    stall_d = stall_q;
    sweep_d = sweep_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (stall_inc && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (sweep_inc && (sweep_q != 16'hFFFF)) begin
      sweep_d = sweep_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      sweep_q <= '0;
    end else begin
      stall_q <= stall_d;
      sweep_q <= sweep_d;
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_sweep_cnt = sweep_q;

endmodule

// File: rtl/hh_weight_read_scheduler.sv
// Row-major sweep sequencer for the W_hh weight memory; owns the write port while idle.
// Optional HH_SCHED_PERF_EN adds saturating stall and sweep counters.
module hh_weight_read_scheduler
  import lstm_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 14,
  parameter int HIDDEN_SIZE = 128,
  parameter int TOTAL_WORDS = 8192
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
`ifdef HH_SCHED_PERF_EN
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_sweep_cnt,
`endif
  output sched_state_e dbg_state,
  hh_weight_read_scheduler_if.slave bus
);

  localparam int WA  = ADDR_WIDTH - 1;
  localparam int WPR = HIDDEN_SIZE / 2;
  localparam int CW  = $clog2(WPR);
  localparam int RW  = $clog2(HIDDEN_SIZE);
  localparam logic [WA-1:0] LAST_ADDR = WA'(TOTAL_WORDS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(WPR - 1);

  sched_state_e            state_q, state_d;
  logic [WA-1:0]           addr_q, addr_d;
  logic                    issue;
  logic                    ld_ready_w;
  logic                    ld_accept;

  logic                    rd_valid_q, rd_valid_d;
  logic [RW-1:0]           rd_row_q, rd_row_d;
  logic [CW-1:0]           rd_col_q, rd_col_d;
  logic                    rd_row_last_q, rd_row_last_d;
  logic                    rd_frame_last_q, rd_frame_last_d;

  logic                    mem_we_q, mem_we_d;
  logic [WA-1:0]           mem_waddr_q, mem_waddr_d;
  logic [2*DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // start has priority over a same-cycle loader request.
  assign ld_ready_w = (state_q == ST_IDLE) && !start;
  assign ld_accept  = bus.ld_valid && ld_ready_w;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          addr_d  = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          addr_d  = '0;
        end else if (bus.mac_ready) begin
          issue = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read tags are captured in the issue cycle so they line up with read_data.
  always_comb begin
    rd_valid_d      = issue;
    rd_row_d        = rd_row_q;
    rd_col_d        = rd_col_q;
    rd_row_last_d   = rd_row_last_q;
    rd_frame_last_d = rd_frame_last_q;
    if (issue) begin
      rd_row_d        = addr_q[WA-1:CW];
      rd_col_d        = addr_q[CW-1:0];
      rd_row_last_d   = (addr_q[CW-1:0] == COL_LAST);
      rd_frame_last_d = (addr_q == LAST_ADDR);
    end
  end

  always_comb begin
    mem_we_d    = ld_accept;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    if (ld_accept) begin
      mem_waddr_d = bus.ld_addr;
      mem_wdata_d = bus.ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      rd_valid_q      <= 1'b0;
      rd_row_q        <= '0;
      rd_col_q        <= '0;
      rd_row_last_q   <= 1'b0;
      rd_frame_last_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_waddr_q     <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      rd_valid_q      <= rd_valid_d;
      rd_row_q        <= rd_row_d;
      rd_col_q        <= rd_col_d;
      rd_row_last_q   <= rd_row_last_d;
      rd_frame_last_q <= rd_frame_last_d;
      mem_we_q        <= mem_we_d;
      mem_waddr_q     <= mem_waddr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign bus.ld_ready      = ld_ready_w && !rst;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_waddr     = mem_waddr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_re        = issue;
  assign bus.mem_raddr     = addr_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_row        = rd_row_q;
  assign bus.rd_col        = rd_col_q;
  assign bus.rd_row_last   = rd_row_last_q;
  assign bus.rd_frame_last = rd_frame_last_q;
  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign dbg_state         = state_q;

`ifdef HH_SCHED_PERF_EN
  hh_sched_perf_counters u_perf (
    .clk            (clk),
    .rst            (rst),
    .stall_inc      ((state_q == ST_RUN) && !bus.mac_ready),
    .stall_clr      ((state_q == ST_IDLE) && start),
    .sweep_inc      (state_q == ST_DONE),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_sweep_cnt (perf_sweep_cnt)
  );
`endif

endmodule

// File: tb/tb_hh_weight_read_scheduler.sv
// Directed bench for hh_weight_read_scheduler: full sweep, stall, loader writes, abort, async reset.
module tb_hh_weight_read_scheduler;
  import lstm_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  sched_state_e dbg_state;
`ifdef HH_SCHED_PERF_EN
  logic [15:0] perf_stall_cnt, perf_sweep_cnt;
`endif

  hh_weight_read_scheduler_if #(.DATA_WIDTH(16), .ADDR_WIDTH(14), .HIDDEN_SIZE(128)) bus ();

  hh_weight_read_scheduler #(
    .DATA_WIDTH(16), .ADDR_WIDTH(14), .HIDDEN_SIZE(128), .TOTAL_WORDS(8192)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
`ifdef HH_SCHED_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_sweep_cnt (perf_sweep_cnt),
`endif
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: bench-owned address model and expected tag queue
  logic [12:0] exp_addr = '0;
  logic [12:0] exp_q[$];
  int rv_cnt = 0, rl_cnt = 0, fl_cnt = 0, done_cnt = 0;
  int last_issue_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) chk("we_only_idle", {31'd0, busy}, 32'd0);
      if (bus.mem_re) begin
        chk("raddr", {19'd0, bus.mem_raddr}, {19'd0, exp_addr});
        exp_q.push_back(exp_addr);
        if (exp_addr == 13'd8191) last_issue_cyc = cyc;
        exp_addr = exp_addr + 13'd1;
      end
      if (bus.rd_valid) begin
        chk("rd_q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [12:0] a;
          a = exp_q.pop_front();
          chk("rd_row", {25'd0, bus.rd_row}, {25'd0, a[12:6]});
          chk("rd_col", {26'd0, bus.rd_col}, {26'd0, a[5:0]});
          chk("rd_row_last", {31'd0, bus.rd_row_last}, {31'd0, a[5:0] == 6'd63});
          chk("rd_frame_last", {31'd0, bus.rd_frame_last}, {31'd0, a == 13'd8191});
        end
        rv_cnt++;
        if (bus.rd_row_last) rl_cnt++;
        if (bus.rd_frame_last) fl_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    exp_addr = '0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_raddr(input logic [12:0] tgt, input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.mem_re && bus.mem_raddr == tgt) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  initial begin
    bus.mac_ready = 1'b1;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;

    // reset state
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_re", {31'd0, bus.mem_re}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("rst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    chk("rst_raddr", {19'd0, bus.mem_raddr}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ld_ready", {31'd0, bus.ld_ready}, 32'd1);

    // loader write in IDLE
    step();
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 13'h1ABC;
    bus.ld_data  = 32'hDEADBEEF;
    step();
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("ld_we", {31'd0, bus.mem_we}, 32'd1);
    chk("ld_waddr", {19'd0, bus.mem_waddr}, 32'h1ABC);
    chk("ld_wdata", bus.mem_wdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("ld_we_drop", {31'd0, bus.mem_we}, 32'd0);

    // start + ld_valid together, then a full unstalled sweep
    step();
    rv_cnt = 0; rl_cnt = 0; fl_cnt = 0; done_cnt = 0;
    exp_addr = '0;
    start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 13'h0055;
    bus.ld_data  = 32'h12345678;
    @(negedge clk);
    chk("start_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    step();
    start = 1'b0;
    bus.ld_valid = 1'b0;
    @(negedge clk);
    chk("start_no_we", {31'd0, bus.mem_we}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_addr0", {19'd0, bus.mem_raddr}, 32'd0);
    wait_done(9000, "sweep1_done");
    step();
    chk("sweep1_rv_cnt", rv_cnt, 32'd8192);
    chk("sweep1_row_last", rl_cnt, 32'd128);
    chk("sweep1_frame_last", fl_cnt, 32'd1);
    chk("sweep1_done_cnt", done_cnt, 32'd1);
    chk("sweep1_done_lat", done_cyc - last_issue_cyc, 32'd2);
    chk("sweep1_q_empty", exp_q.size(), 32'd0);
    @(negedge clk);
    chk("sweep1_idle", {31'd0, busy}, 32'd0);

    // stall five cycles at addr 100, then abort at addr 300
    step();
    pulse_start();
    wait_raddr(13'd100, 200, "reach_100");
    bus.mac_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_no_re", {31'd0, bus.mem_re}, 32'd0);
      chk("stall_hold", {19'd0, bus.mem_raddr}, 32'd100);
      step();
    end
    bus.mac_ready = 1'b1;
    @(negedge clk);
`ifdef HH_SCHED_PERF_EN
    chk("perf_stall", {16'd0, perf_stall_cnt}, 32'd5);
`endif
    chk("resume_addr", {19'd0, bus.mem_raddr}, 32'd100);
    wait_raddr(13'd300, 400, "reach_300");
    abort = 1'b1;
    @(negedge clk);
    chk("abort_no_re", {31'd0, bus.mem_re}, 32'd0);
    chk("abort_trail_valid", {31'd0, bus.rd_valid}, 32'd1);
    chk("abort_trail_row", {25'd0, bus.rd_row}, 32'd4);
    chk("abort_trail_col", {26'd0, bus.rd_col}, 32'd43);
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_no_trail2", {31'd0, bus.rd_valid}, 32'd0);
    chk("abort_no_done", done_cnt, 32'd1);
    chk("abort_q_empty", exp_q.size(), 32'd0);

    // restart, then asynchronous reset at addr 4000
    step();
    pulse_start();
    @(negedge clk);
    chk("restart_re", {31'd0, bus.mem_re}, 32'd1);
    chk("restart_addr0", {19'd0, bus.mem_raddr}, 32'd0);
    wait_raddr(13'd4000, 4100, "reach_4000");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_mem_re", {31'd0, bus.mem_re}, 32'd0);
    chk("arst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
    chk("arst_raddr", {19'd0, bus.mem_raddr}, 32'd0);
    chk("arst_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
    exp_q.delete();
    exp_addr = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ld_ready", {31'd0, bus.ld_ready}, 32'd1);
    step();
    pulse_start();
    @(negedge clk);
    chk("post_rst_addr0", {19'd0, bus.mem_raddr}, 32'd0);
    wait_raddr(13'd3, 10, "post_rst_reach_3");
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
